// File: rtl/risc_v_lsu_pkg.sv
// Shared definitions for the load/store unit: access types, FSM states, error codes.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package risc_v_lsu_pkg;

  // func3 access types
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  // completion error codes
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsigned variants only make sense for loads.
  function automatic logic rw_legal(input logic we, input logic [2:0] rw);
    case (rw)
      RW_B, RW_H, RW_W: return 1'b1;
      RW_BU, RW_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic rw_misaligned(input logic [2:0] rw, input logic [1:0] off);
    case (rw)
      RW_H, RW_HU: return off[0];
      RW_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Offset rounded down to the natural alignment of the access size.
  function automatic logic [1:0] rw_align_off(input logic [2:0] rw, input logic [1:0] off);
    case (rw)
      RW_H, RW_HU: return {off[1], 1'b0};
      RW_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_lsu_align.sv
// Byte-lane steering: store byte enables/replicated data and load extract/extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rw_type/offset select the lanes; wdata -> be, wdata_lane; rdata -> rdata_ext.
module risc_v_lsu_align
  import risc_v_lsu_pkg::*;
(
  input  logic [2:0]  rw_type,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    case (rw_type)
      RW_B: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      RW_BU: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {24'h0, byte_sel};
      end
      RW_H: begin
        be         = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      RW_HU: begin
        be         = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, half_sel};
      end
      RW_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_v_lsu.sv
// Load/store unit: checks a core access, runs one handshaked bus transfer, returns extended data.
// Latency: core_done 2 cycles after accept with ack in first bus cycle; error paths 1 cycle.
// Backpressure: core_ready low while busy; mem_* held stable until mem_ack or timeout.
// Ports: core_* request/response to execute stage; mem_* word-aligned data bus; clk, rst (async high).
module risc_v_lsu
  import risc_v_lsu_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT       = 16,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_rw_type,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_ready,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  output logic [1:0]        core_err_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        rw_q, rw_d;
  logic [1:0]        off_q, off_d;

  logic              core_ready_d, core_done_d, core_err_d;
  logic [31:0]       core_rdata_d;
  logic [1:0]        core_err_code_d;
  logic              mem_req_d, mem_we_d;
  logic [3:0]        mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  // One steering instance: fed from the core in IDLE (store lanes), from the
  // latched access in BUS (load extraction).
  logic [1:0]  off_eff, al_off;
  logic [2:0]  al_rw;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  // Without trapping, misaligned accesses proceed at the rounded-down offset.
  assign off_eff = rw_align_off(core_rw_type, core_addr[1:0]);
  assign al_rw   = (state_q == ST_IDLE) ? core_rw_type : rw_q;
  assign al_off  = (state_q == ST_IDLE) ? off_eff : off_q;

  risc_v_lsu_align u_align (
    .rw_type    (al_rw),
    .offset     (al_off),
    .wdata      (core_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      rw_q          <= 3'b000;
      off_q         <= 2'b00;
      core_ready    <= 1'b1;
      core_done     <= 1'b0;
      core_rdata    <= 32'h0;
      core_err      <= 1'b0;
      core_err_code <= ERR_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_be        <= 4'b0000;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      rw_q          <= rw_d;
      off_q         <= off_d;
      core_ready    <= core_ready_d;
      core_done     <= core_done_d;
      core_rdata    <= core_rdata_d;
      core_err      <= core_err_d;
      core_err_code <= core_err_code_d;
      mem_req       <= mem_req_d;
      mem_we        <= mem_we_d;
      mem_be        <= mem_be_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    rw_d            = rw_q;
    off_d           = off_q;
    core_rdata_d    = core_rdata;
    core_err_d      = core_err;
    core_err_code_d = core_err_code;
    mem_req_d       = mem_req;
    mem_we_d        = mem_we;
    mem_be_d        = mem_be;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;

    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
          we_d  = core_we;
          rw_d  = core_rw_type;
          off_d = off_eff;
          if (!rw_legal(core_we, core_rw_type)) begin
            state_d         = ST_RESP;
            core_err_d      = 1'b1;
            core_err_code_d = ERR_ILLEGAL;
            core_rdata_d    = 32'h0;
          end else if (MISALIGN_TRAP && rw_misaligned(core_rw_type, core_addr[1:0])) begin
            state_d         = ST_RESP;
            core_err_d      = 1'b1;
            core_err_code_d = ERR_MISALIGN;
            core_rdata_d    = 32'h0;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = core_we;
            mem_be_d    = al_be;
            mem_addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = al_wdata;
          end
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (mem_ack) begin
          state_d         = ST_RESP;
          mem_req_d       = 1'b0;
          core_err_d      = 1'b0;
          core_err_code_d = ERR_NONE;
          core_rdata_d    = we_q ? 32'h0 : al_rdata;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d         = ST_RESP;
          mem_req_d       = 1'b0;
          core_err_d      = 1'b1;
          core_err_code_d = ERR_TIMEOUT;
          core_rdata_d    = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    core_ready_d = (state_d == ST_IDLE);
    core_done_d  = (state_d == ST_RESP);
  end

endmodule

// File: tb/tb_risc_v_lsu.sv
// Bench for risc_v_lsu: directed vector table, hand-written timeout/reset sequences, random accesses vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_risc_v_lsu;
  import risc_v_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_rw_type;
  logic [31:0] core_addr, core_wdata;
  logic        core_ready, core_done, core_err;
  logic [31:0] core_rdata;
  logic [1:0]  core_err_code;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  risc_v_lsu #(.ADDR_W(32), .TIMEOUT(16), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_rw_type(core_rw_type),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_done(core_done), .core_rdata(core_rdata),
    .core_err(core_err), .core_err_code(core_err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_addr;
    logic [31:0] e_rd;
    logic [1:0]  e_code;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size from func3, lanes by shift/multiply, extension by arithmetic.
  function automatic void ref_model(input logic we, input logic [2:0] rw,
                                    input logic [31:0] addr, wdata, rdata,
                                    output logic [3:0] be, output logic [31:0] wd,
                                    output logic [31:0] maddr, output logic [31:0] rd,
                                    output logic [1:0] code);
    int     size, o, bits;
    logic   legal;
    longint v;
    o     = int'(addr[1:0]);
    size  = (rw[1:0] == 2'd0) ? 1 : (rw[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (rw <= 3'd2) : (rw <= 3'd2 || rw == 3'd4 || rw == 3'd5);
    maddr = addr & 32'hFFFF_FFFC;
    be    = 4'(((1 << size) - 1) << o);
    wd    = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
            (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    bits  = 8 * size;
    v     = (longint'(rdata) >> (8 * o)) & ((64'd1 << bits) - 1);
    if (!rw[2] && size < 4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    rd    = we ? 32'h0 : v[31:0];
    if (!legal) code = ERR_ILLEGAL;
    else if ((o % size) != 0) code = ERR_MISALIGN;
    else code = ERR_NONE;
    if (code != ERR_NONE) rd = 32'h0;
  endfunction

  task automatic do_access(input string nm, input logic we, input logic [2:0] rw,
                           input logic [31:0] addr, wdata, rdata, input int dly,
                           input logic [3:0] e_be, input logic [31:0] e_wd,
                           input logic [31:0] e_addr, input logic [31:0] e_rd,
                           input logic [1:0] e_code);
    int n;
    n = 0;
    while (!core_ready && n < 50) begin
      step();
      n++;
    end
    chk({nm, ".ready"}, 32'(core_ready), 32'd1);
    core_req = 1'b1; core_we = we; core_rw_type = rw; core_addr = addr; core_wdata = wdata;
    step();
    // Scramble request fields: the unit must use its latched copy.
    core_req = 1'b0; core_we = 1'($urandom); core_rw_type = 3'($urandom);
    core_addr = $urandom; core_wdata = $urandom;
    if (e_code != ERR_NONE) begin
      chk({nm, ".err_done"}, 32'(core_done), 32'd1);
      chk({nm, ".err_flag"}, 32'(core_err), 32'd1);
      chk({nm, ".err_code"}, 32'(core_err_code), 32'(e_code));
      chk({nm, ".err_rdata"}, core_rdata, 32'h0);
      chk({nm, ".err_no_memreq"}, 32'(mem_req), 32'd0);
    end else begin
      chk({nm, ".mem_req"}, 32'(mem_req), 32'd1);
      chk({nm, ".mem_addr"}, mem_addr, e_addr);
      chk({nm, ".mem_be"}, 32'(mem_be), 32'(e_be));
      chk({nm, ".mem_we"}, 32'(mem_we), 32'(we));
      if (we) chk({nm, ".mem_wdata"}, mem_wdata, e_wd);
      for (int i = 0; i < dly; i++) begin
        step();
        chk({nm, ".hold"}, {mem_addr[31:2], mem_req, core_done}, {e_addr[31:2], 1'b1, 1'b0});
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk({nm, ".done"}, 32'(core_done), 32'd1);
      chk({nm, ".req_drop"}, 32'(mem_req), 32'd0);
      chk({nm, ".ok_code"}, {29'h0, core_err, core_err_code}, 32'h0);
      chk({nm, ".rdata"}, core_rdata, e_rd);
    end
    step();
    chk({nm, ".pulse_ready"}, {30'h0, core_done, core_ready}, 32'h1);
    if (e_code == ERR_NONE) chk({nm, ".rdata_held"}, core_rdata, e_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, dones;
    logic        we;
    logic [2:0]  rw;
    logic [31:0] addr, wdata, rdata, e_wd, e_addr, e_rd;
    logic [3:0]  e_be;
    logic [1:0]  e_code;
    logic [2:0]  legal_rw[5];

    legal_rw = '{RW_B, RW_H, RW_W, RW_BU, RW_HU};
    //            name          we    rw      addr          wdata         rdata         dly be       wdata exp     addr exp      rdata exp     code
    tbl[0]  = '{"sw_word",     1'b1, RW_W,   32'h104,      32'hDEADBEEF, 32'h0,        0,  4'b1111, 32'hDEADBEEF, 32'h104, 32'h0,        ERR_NONE};
    tbl[1]  = '{"lb_sign",     1'b0, RW_B,   32'h103,      32'h0,        32'h80FF0011, 0,  4'b1000, 32'h0,        32'h100, 32'hFFFFFF80, ERR_NONE};
    tbl[2]  = '{"lbu_zero",    1'b0, RW_BU,  32'h103,      32'h0,        32'h80FF0011, 0,  4'b1000, 32'h0,        32'h100, 32'h00000080, ERR_NONE};
    tbl[3]  = '{"sh_upper",    1'b1, RW_H,   32'h22,       32'h0000ABCD, 32'h0,        1,  4'b1100, 32'hABCDABCD, 32'h20,  32'h0,        ERR_NONE};
    tbl[4]  = '{"lw_misal",    1'b0, RW_W,   32'h102,      32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        ERR_MISALIGN};
    tbl[5]  = '{"lh_misal",    1'b0, RW_H,   32'h101,      32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        ERR_MISALIGN};
    tbl[6]  = '{"lhu_upper",   1'b0, RW_HU,  32'h102,      32'h0,        32'h80FF0011, 2,  4'b1100, 32'h0,        32'h100, 32'h000080FF, ERR_NONE};
    tbl[7]  = '{"lh_sign",     1'b0, RW_H,   32'h200,      32'h0,        32'h12348001, 0,  4'b0011, 32'h0,        32'h200, 32'hFFFF8001, ERR_NONE};
    tbl[8]  = '{"ld_illegal",  1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        ERR_ILLEGAL};
    tbl[9]  = '{"sbu_illegal", 1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        ERR_ILLEGAL};
    tbl[10] = '{"sb_lane1",    1'b1, RW_B,   32'h1,        32'h1234565A, 32'h0,        0,  4'b0010, 32'h5A5A5A5A, 32'h0,   32'h0,        ERR_NONE};
    tbl[11] = '{"lw_ack_last", 1'b0, RW_W,   32'h8,        32'h0,        32'hCAFEF00D, 15, 4'b1111, 32'h0,        32'h8,   32'hCAFEF00D, ERR_NONE};
    tbl[12] = '{"ill_over_mis",1'b1, 3'b110, 32'h3,        32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        ERR_ILLEGAL};
    tbl[13] = '{"lbu_lane0",   1'b0, RW_BU,  32'h4,        32'h0,        32'h000000FE, 3,  4'b0001, 32'h0,        32'h4,   32'h000000FE, ERR_NONE};

    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_rw_type = 3'b000;
    core_addr = 32'h0; core_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("reset.ready", 32'(core_ready), 32'd1);
    chk("reset.outs", {core_done, core_err, core_err_code, mem_req, mem_we, mem_be}, 32'h0);
    chk("reset.data", core_rdata | mem_addr | mem_wdata, 32'h0);
    rst = 1'b0;

    foreach (tbl[i])
      do_access(tbl[i].nm, tbl[i].we, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                tbl[i].dly, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_addr, tbl[i].e_rd, tbl[i].e_code);

    // Timeout: ack withheld, mem_req must stay up exactly 16 cycles.
    core_req = 1'b1; core_we = 1'b0; core_rw_type = RW_W; core_addr = 32'h40;
    step();
    core_req = 1'b0;
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("tmo.req_cycles", 32'(cnt), 32'd16);
    chk("tmo.done", 32'(core_done), 32'd1);
    chk("tmo.code", {29'h0, core_err, core_err_code}, {29'h0, 1'b1, ERR_TIMEOUT});
    chk("tmo.rdata", core_rdata, 32'h0);
    step();
    chk("tmo.idle", 32'(core_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("tmo.late_ack", {29'h0, core_done, mem_req, core_ready}, 32'h1);

    // Reset in BUS after 3 wait cycles: mem_req drops at once, no done.
    core_req = 1'b1; core_we = 1'b0; core_rw_type = RW_W; core_addr = 32'h80;
    step();
    core_req = 1'b0;
    chk("rst.in_bus", 32'(mem_req), 32'd1);
    step(); step();
    #3 rst = 1'b1;
    #1 chk("rst.async_drop", {30'h0, mem_req, core_done}, 32'h0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (core_done) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (core_done) dones++;
    end
    chk("rst.no_done", 32'(dones), 32'd0);
    chk("rst.ready", 32'(core_ready), 32'd1);
    do_access("rst.lw_after", 1'b0, RW_W, 32'h84, 32'h0, 32'h11223344, 1,
              4'b1111, 32'h0, 32'h84, 32'h11223344, ERR_NONE);

    // Random accesses checked against the reference model.
    for (int t = 0; t < 60; t++) begin
      we    = 1'($urandom_range(0, 1));
      rw    = ($urandom_range(0, 3) != 0) ? legal_rw[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      ref_model(we, rw, addr, wdata, rdata, e_be, e_wd, e_addr, e_rd, e_code);
      do_access("rand", we, rw, addr, wdata, rdata, $urandom_range(0, 15),
                e_be, e_wd, e_addr, e_rd, e_code);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
